// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing a 64x8 asynchronous-strobe memory.
// Each granted access runs a fixed SETUP / STROBE / HOLD / DONE sequence with registered outputs.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_READ,
  output logic              mem_WRITE,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;    // port granted most recently
  logic                owner_q, owner_d;  // port owning the current transaction
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                drive_q, drive_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                busy_q, busy_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                in_txn;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? ~last_q : req1;
          last_d  = owner_d;
          we_d    = owner_d ? we1    : we0;
          addr_d  = owner_d ? addr1  : addr0;
          wdata_d = owner_d ? wdata1 : wdata0;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        // The memory is still driving the bus here because mem_READ stays high through HOLD.
        if (!we_q) rdata_d = mem_data;
        state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered, aligned with the state.
    in_txn  = (state_d != S_IDLE);
    gnt0_d  = in_txn && !owner_d;
    gnt1_d  = in_txn &&  owner_d;
    done0_d = (state_d == S_DONE) && !owner_d;
    done1_d = (state_d == S_DONE) &&  owner_d;
    busy_d  = in_txn;
    read_d  = !we_d && ((state_d == S_STROBE) || (state_d == S_HOLD));
    write_d =  we_d &&  (state_d == S_STROBE);
    drive_d =  we_d && ((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD));
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments, and reset clears every register including data.
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      drive_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      drive_q <= drive_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  assign mem_data    = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign mem_address = addr_q;
  assign mem_READ    = read_q;
  assign mem_WRITE   = write_q;
  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign busy        = busy_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a strobe-driven memory model on the bus, and a
// transaction-level reference (round-robin owner, expected memory contents, expected rdata).
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, busy, mem_READ, mem_WRITE;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_address;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] mem     [0:63];  // the physical memory on the bus
  logic [DW-1:0] exp_mem [0:63];  // what the memory should hold, updated per transaction
  logic [DW-1:0] exp_rdata;
  int            last;            // port granted most recently
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .mem_address(mem_address),
    .mem_READ(mem_READ), .mem_WRITE(mem_WRITE), .mem_data(mem_data)
  );

  // Asynchronous-strobe memory: drives data while READ is high, latches on the rising WRITE.
  assign mem_data = mem_READ ? mem[mem_address] : {DW{1'bz}};
  always @(posedge mem_WRITE) mem[mem_address] = mem_data;

  // An undriven bus may resolve to z or to 0 depending on the simulator.
  function automatic bit released();
    return (mem_data === {DW{1'b0}}) || (mem_data === {DW{1'bz}});
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ((gnt0 && gnt1) || (mem_READ && mem_WRITE) || (busy !== (gnt0 || gnt1))) begin
        errors++;
        $display("FAIL invariant t=%0t gnt0=%b gnt1=%b READ=%b WRITE=%b busy=%b", $time,
                 gnt0, gnt1, mem_READ, mem_WRITE, busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last = 1;
    exp_rdata = '0;
    @(negedge clk);
  endtask

  // Starts at a negedge in IDLE with the request inputs already set. Predicts the winner from
  // the round-robin rule and checks all five cycles (SETUP, STROBE, HOLD, DONE, IDLE).
  task automatic run_round(input bit keep, input bit perturb);
    int            w;
    bit            we_l;
    logic [AW-1:0] a_l;
    logic [DW-1:0] d_l;
    logic [6:0]    exp_ctrl;
    if (!req0 && !req1) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, busy} !== 3'b000) begin
        errors++;
        $display("FAIL idle_no_req got gnt0/gnt1/busy=%b want 000", {gnt0, gnt1, busy});
      end
      return;
    end
    w    = (req0 && req1) ? (last == 0 ? 1 : 0) : (req0 ? 0 : 1);
    we_l = (w == 0) ? we0    : we1;
    a_l  = (w == 0) ? addr0  : addr1;
    d_l  = (w == 0) ? wdata0 : wdata1;
    last = w;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_ctrl = {c <= 4 && w == 0, c <= 4 && w == 1, c == 4 && w == 0, c == 4 && w == 1,
                  c <= 4, !we_l && (c == 2 || c == 3), we_l && c == 2};
      if (c == 4 && !we_l) exp_rdata = exp_mem[a_l];
      checks++;
      if ({gnt0, gnt1, done0, done1, busy, mem_READ, mem_WRITE} !== exp_ctrl) begin
        errors++;
        $display("FAIL ctrl cycle %0d port %0d got g0,g1,d0,d1,busy,R,W=%b want %b", c, w,
                 {gnt0, gnt1, done0, done1, busy, mem_READ, mem_WRITE}, exp_ctrl);
      end
      checks++;
      if (mem_address !== a_l) begin
        errors++;
        $display("FAIL address cycle %0d got %h want %h", c, mem_address, a_l);
      end
      checks++;
      if (we_l && c <= 3) begin
        if (mem_data !== d_l) begin
          errors++;
          $display("FAIL bus_write cycle %0d got %h want %h", c, mem_data, d_l);
        end
      end else if (!we_l && (c == 2 || c == 3)) begin
        if (mem_data !== exp_mem[a_l]) begin
          errors++;
          $display("FAIL bus_read cycle %0d got %h want %h", c, mem_data, exp_mem[a_l]);
        end
      end else if (!released()) begin
        errors++;
        $display("FAIL bus_release cycle %0d got %h want z", c, mem_data);
      end
      checks++;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rdata cycle %0d got %h want %h", c, rdata, exp_rdata);
      end
      if (c == 1 && perturb) begin
        if (w == 0) begin
          req0 = 1'b0; we0 = ~we0; addr0 = addr0 ^ 6'h04; wdata0 = ~wdata0;
        end else begin
          req1 = 1'b0; we1 = ~we1; addr1 = addr1 ^ 6'h04; wdata1 = ~wdata1;
        end
      end
      if (c == 4 && !keep) begin
        if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    if (we_l) exp_mem[a_l] = d_l;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, mem_READ, mem_WRITE} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {gnt0, gnt1, done0, done1, busy, mem_READ, mem_WRITE});
    end
    checks++;
    if (mem_address !== '0 || rdata !== '0 || !released()) begin
      errors++;
      $display("FAIL reset_data got addr=%h rdata=%h bus=%h want 00 00 z",
               mem_address, rdata, mem_data);
    end
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h05;
    run_round(1'b0, 1'b0);
    checks++;
    if (rdata !== 8'hA7) begin
      errors++;
      $display("FAIL single_read_rdata got %h want a7", rdata);
    end
  endtask

  task automatic test_write_then_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h2A; wdata1 = 8'h3C;
    run_round(1'b0, 1'b0);
    req1 = 1'b1; we1 = 1'b0;
    run_round(1'b0, 1'b0);
    checks++;
    if (rdata !== 8'h3C) begin
      errors++;
      $display("FAIL write_read_rdata got %h want 3c", rdata);
    end
  endtask

  task automatic test_round_robin();
    int winners [4];
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h05;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'h2A;
    for (int k = 0; k < 4; k++) begin
      run_round(1'b1, 1'b0);
      winners[k] = last;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (winners[0] != 0 || winners[1] != 1 || winners[2] != 0 || winners[3] != 1) begin
      errors++;
      $display("FAIL rr_order got %0d%0d%0d%0d want 0101",
               winners[0], winners[1], winners[2], winners[3]);
    end
  endtask

  task automatic test_rdata_hold();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h10;
    run_round(1'b0, 1'b0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h10; wdata1 = ~exp_mem[6'h10];
    run_round(1'b0, 1'b0);
    req0 = 1'b1;
    run_round(1'b0, 1'b0);
  endtask

  task automatic test_addr_change();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h03; wdata0 = 8'h00;
    run_round(1'b0, 1'b1);
    checks++;
    if (rdata !== 8'h33) begin
      errors++;
      $display("FAIL addr_change_rdata got %h want 33", rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h01; wdata1 = 8'h55;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_WRITE !== 1'b1) begin
      errors++;
      $display("FAIL strobe_before_reset got WRITE=%b want 1", mem_WRITE);
    end
    reset = 1'b1; req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, mem_READ, mem_WRITE} !== 7'b0 ||
        mem_address !== '0 || rdata !== '0 || !released()) begin
      errors++;
      $display("FAIL midreset got ctrl=%b addr=%h rdata=%h bus=%h want 0 00 00 z",
               {gnt0, gnt1, done0, done1, busy, mem_READ, mem_WRITE}, mem_address, rdata, mem_data);
    end
    reset = 1'b0;
    last = 1; exp_rdata = '0; exp_mem[6'h01] = 8'h55;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'h02;
    run_round(1'b0, 1'b0);
    run_round(1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if (!req0 && $urandom_range(1, 0) == 1) begin
        req0 = 1'b1; we0 = 1'($urandom_range(1, 0));
        addr0 = AW'($urandom); wdata0 = DW'($urandom);
      end
      if (!req1 && $urandom_range(1, 0) == 1) begin
        req1 = 1'b1; we1 = 1'($urandom_range(1, 0));
        addr1 = AW'($urandom); wdata1 = DW'($urandom);
      end
      run_round(1'b0, 1'($urandom_range(3, 0) == 0));
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    mem[6'h05] = 8'hA7;
    mem[6'h03] = 8'h33;
    mem[6'h07] = 8'h77;
    for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];

    test_reset();
    test_single_read();
    test_write_then_read();
    test_round_robin();
    test_rdata_hold();
    test_addr_change();
    test_reset_mid_write();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
